// File: rtl/mc_if.sv
// Handshake and control bundle between the multi-cycle controller and the
// MIPS datapath/memory. The controller sits on the slave side.
interface mc_if #(
   parameter int ALU_OP_W = 4
);
   logic [5:0]          op;
   logic [5:0]          func;
   logic                eq;
   logic                mem_ready;
   logic                imem_req;
   logic                dmem_req;
   logic                mem_write;
   logic                ir_write;
   logic                pc_write;
   logic                reg_write;
   logic                control_a;
   logic                control_b;
   logic                sign_ext;
   logic                dest;
   logic                jal;
   logic                mem_to_reg;
   logic [ALU_OP_W-1:0] alu_op;
   logic [1:0]          next_op;
   logic                illegal;
   logic                bus_err;
   logic                instr_done;
   logic [2:0]          state;

   modport slave (
      input  op, func, eq, mem_ready,
      output imem_req, dmem_req, mem_write, ir_write, pc_write, reg_write,
             control_a, control_b, sign_ext, dest, jal, mem_to_reg,
             alu_op, next_op, illegal, bus_err, instr_done, state
   );

   modport master (
      output op, func, eq, mem_ready,
      input  imem_req, dmem_req, mem_write, ir_write, pc_write, reg_write,
             control_a, control_b, sign_ext, dest, jal, mem_to_reg,
             alu_op, next_op, illegal, bus_err, instr_done, state
   );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// memory ready handshake, illegal-instruction trap and optional memory timeout.
module mc_controller #(
   parameter int ALU_OP_W    = 4,
   parameter int MEM_TIMEOUT = 0
) (
   input logic  clk,
   input logic  rst_n,
   mc_if.slave  bus
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_ILL
   } class_t;

   localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4);
   localparam logic [ALU_OP_W-1:0] ALU_NOR  = ALU_OP_W'(5);
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(6);
   localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(7);
   localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(8);
   localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(9);
   localparam logic [ALU_OP_W-1:0] ALU_LUI  = ALU_OP_W'(10);
   localparam logic [ALU_OP_W-1:0] ALU_NONE = '1;

   // The wait counter only ever needs to hold MEM_TIMEOUT-1 before it fires.
   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t              r_state;
   state_t              w_nextState;
   logic [CNT_W-1:0]    r_waitCnt;
   class_t              w_class;
   logic [ALU_OP_W-1:0] w_aluOp;
   logic                w_ctlA, w_ctlB, w_sext, w_dest, w_isBne, w_taken;
   logic                w_waiting, w_timeout;
   logic                w_imemReq, w_dmemReq, w_memWrite, w_irWrite, w_pcWrite;
   logic                w_regWrite, w_illegal, w_busErr, w_done;
   logic [1:0]          w_nextOp;

   always_comb begin
      w_class = C_ILL;
      w_aluOp = ALU_NONE;
      w_ctlA  = 1'b0;
      w_ctlB  = 1'b0;
      w_sext  = 1'b0;
      w_dest  = 1'b0;
      case (bus.op)
         6'b000000: begin
            case (bus.func)
               6'b100000, 6'b100001: begin w_class = C_ALU; w_aluOp = ALU_ADD; w_dest = 1'b1; end
               6'b100010, 6'b100011: begin w_class = C_ALU; w_aluOp = ALU_SUB; w_dest = 1'b1; end
               6'b100100:            begin w_class = C_ALU; w_aluOp = ALU_AND; w_dest = 1'b1; end
               6'b100101:            begin w_class = C_ALU; w_aluOp = ALU_OR;  w_dest = 1'b1; end
               6'b100110:            begin w_class = C_ALU; w_aluOp = ALU_XOR; w_dest = 1'b1; end
               6'b100111:            begin w_class = C_ALU; w_aluOp = ALU_NOR; w_dest = 1'b1; end
               6'b101010, 6'b101011: begin w_class = C_ALU; w_aluOp = ALU_SLT; w_dest = 1'b1; end
               6'b000000: begin w_class = C_ALU; w_aluOp = ALU_SLL; w_dest = 1'b1; w_ctlA = 1'b1; end
               6'b000010: begin w_class = C_ALU; w_aluOp = ALU_SRL; w_dest = 1'b1; w_ctlA = 1'b1; end
               6'b000011: begin w_class = C_ALU; w_aluOp = ALU_SRA; w_dest = 1'b1; w_ctlA = 1'b1; end
               6'b000100: begin w_class = C_ALU; w_aluOp = ALU_SLL; w_dest = 1'b1; end
               6'b000110: begin w_class = C_ALU; w_aluOp = ALU_SRL; w_dest = 1'b1; end
               6'b000111: begin w_class = C_ALU; w_aluOp = ALU_SRA; w_dest = 1'b1; end
               6'b001000: w_class = C_JR;
               default:   w_class = C_ILL;
            endcase
         end
         6'b001000, 6'b001001: begin w_class = C_ALU; w_aluOp = ALU_ADD; w_ctlB = 1'b1; w_sext = 1'b1; end
         6'b001100: begin w_class = C_ALU; w_aluOp = ALU_AND; w_ctlB = 1'b1; end
         6'b001101: begin w_class = C_ALU; w_aluOp = ALU_OR;  w_ctlB = 1'b1; end
         6'b001110: begin w_class = C_ALU; w_aluOp = ALU_XOR; w_ctlB = 1'b1; end
         6'b001111: begin w_class = C_ALU; w_aluOp = ALU_LUI; w_ctlB = 1'b1; end
         6'b001010: begin w_class = C_ALU; w_aluOp = ALU_SLT; w_ctlB = 1'b1; w_sext = 1'b1; end
         6'b001011: begin w_class = C_ALU; w_aluOp = ALU_SLT; w_ctlB = 1'b1; end
         6'b100011: begin w_class = C_LW;  w_aluOp = ALU_ADD; w_ctlB = 1'b1; w_sext = 1'b1; end
         6'b101011: begin w_class = C_SW;  w_aluOp = ALU_ADD; w_ctlB = 1'b1; w_sext = 1'b1; end
         6'b000100, 6'b000101: begin w_class = C_BR; w_aluOp = ALU_SUB; end
         6'b000010: w_class = C_J;
         6'b000011: w_class = C_JAL;
         default:   w_class = C_ILL;
      endcase
   end

   assign w_isBne   = (bus.op == 6'b000101);
   assign w_taken   = w_isBne ? !bus.eq : bus.eq;
   assign w_waiting = ((r_state == FETCH) || (r_state == MEM)) && !bus.mem_ready;
   assign w_timeout = (MEM_TIMEOUT > 0) && w_waiting && (r_waitCnt == LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Any state change, including a timed-out re-fetch, restarts the wait count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_waitCnt <= '0;
      end else if ((w_nextState != r_state) || w_busErr) begin
         r_waitCnt <= '0;
      end else if (w_waiting) begin
         r_waitCnt <= r_waitCnt + 1'b1;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_imemReq   = 1'b0;
      w_dmemReq   = 1'b0;
      w_memWrite  = 1'b0;
      w_irWrite   = 1'b0;
      w_pcWrite   = 1'b0;
      w_regWrite  = 1'b0;
      w_illegal   = 1'b0;
      w_busErr    = 1'b0;
      w_done      = 1'b0;
      w_nextOp    = 2'b00;
      case (r_state)
         FETCH: begin
            w_imemReq = 1'b1;
            if (bus.mem_ready) begin
               w_irWrite   = 1'b1;
               w_nextState = DECODE;
            end else if (w_timeout) begin
               w_busErr    = 1'b1;
               w_nextState = FETCH;
            end
         end
         DECODE: begin
            if (w_class == C_ILL) begin
               w_illegal   = 1'b1;
               w_pcWrite   = 1'b1;
               w_done      = 1'b1;
               w_nextState = FETCH;
            end else begin
               w_nextState = EXEC;
            end
         end
         EXEC: begin
            case (w_class)
               C_BR: begin
                  w_pcWrite   = 1'b1;
                  w_nextOp    = w_taken ? 2'b01 : 2'b00;
                  w_done      = 1'b1;
                  w_nextState = FETCH;
               end
               C_J: begin
                  w_pcWrite   = 1'b1;
                  w_nextOp    = 2'b10;
                  w_done      = 1'b1;
                  w_nextState = FETCH;
               end
               C_JR: begin
                  w_pcWrite   = 1'b1;
                  w_nextOp    = 2'b11;
                  w_done      = 1'b1;
                  w_nextState = FETCH;
               end
               C_JAL: begin
                  w_pcWrite   = 1'b1;
                  w_regWrite  = 1'b1;
                  w_nextOp    = 2'b10;
                  w_done      = 1'b1;
                  w_nextState = FETCH;
               end
               C_LW, C_SW: w_nextState = MEM;
               default:    w_nextState = WB;
            endcase
         end
         MEM: begin
            w_dmemReq = 1'b1;
            if (bus.mem_ready) begin
               w_memWrite = (w_class == C_SW);
               if (w_class == C_SW) begin
                  w_pcWrite   = 1'b1;
                  w_done      = 1'b1;
                  w_nextState = FETCH;
               end else begin
                  w_nextState = WB;
               end
            end else if (w_timeout) begin
               w_busErr    = 1'b1;
               w_nextState = FETCH;
            end else begin
               w_memWrite = (w_class == C_SW);
            end
         end
         WB: begin
            w_regWrite  = 1'b1;
            w_pcWrite   = 1'b1;
            w_done      = 1'b1;
            w_nextState = FETCH;
         end
         default: w_nextState = FETCH;
      endcase
   end

   // Strobes and requests are forced low for the whole time reset is held.
   assign bus.imem_req   = rst_n & w_imemReq;
   assign bus.dmem_req   = rst_n & w_dmemReq;
   assign bus.mem_write  = rst_n & w_memWrite;
   assign bus.ir_write   = rst_n & w_irWrite;
   assign bus.pc_write   = rst_n & w_pcWrite;
   assign bus.reg_write  = rst_n & w_regWrite;
   assign bus.illegal    = rst_n & w_illegal;
   assign bus.bus_err    = rst_n & w_busErr;
   assign bus.instr_done = rst_n & w_done;
   assign bus.next_op    = w_nextOp;
   assign bus.alu_op     = w_aluOp;
   assign bus.control_a  = w_ctlA;
   assign bus.control_b  = w_ctlB;
   assign bus.sign_ext   = w_sext;
   assign bus.dest       = w_dest;
   assign bus.jal        = (w_class == C_JAL);
   assign bus.mem_to_reg = (w_class == C_LW);
   assign bus.state      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Randomised and directed bench for mc_controller, checked against a
// phase-sequence reference model of the instruction set.
module tb_mc_controller;

   localparam int AW  = 4;
   localparam int TMO = 3;
   localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_J = 4, K_JAL = 5, K_JR = 6, K_ILL = 7;

   typedef struct {
      int kind;
      int alu;
      int ca;
      int cb;
      int se;
      int dst;
   } info_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   testsRun = 0;
   int   failCount = 0;
   int   cycleIdx = 0;
   int   doneAt = 0;

   logic [5:0] opList[$] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e,
                             6'h0f, 6'h0a, 6'h0b, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
   logic [5:0] fnList[$] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};

   mc_if #(.ALU_OP_W(AW)) bus ();

   mc_controller #(.ALU_OP_W(AW), .MEM_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Instruction-set table: what class each encoding is and which control
   // fields it defines (-1 marks a field the instruction leaves unspecified).
   function automatic info_t classify(input logic [5:0] o, input logic [5:0] f);
      info_t r;
      r.kind = K_ILL; r.alu = -1; r.ca = -1; r.cb = -1; r.se = -1; r.dst = -1;
      if (o == 6'h00) begin
         case (f)
            6'h20, 6'h21: r.alu = 0;
            6'h22, 6'h23: r.alu = 1;
            6'h24: r.alu = 2;
            6'h25: r.alu = 3;
            6'h26: r.alu = 4;
            6'h27: r.alu = 5;
            6'h2a, 6'h2b: r.alu = 6;
            default: r.alu = -1;
         endcase
         if (r.alu >= 0) begin
            r.kind = K_ALU; r.dst = 1;
         end else begin
            case (f)
               6'h00: begin r.kind = K_ALU; r.alu = 7; r.ca = 1; end
               6'h02: begin r.kind = K_ALU; r.alu = 8; r.ca = 1; end
               6'h03: begin r.kind = K_ALU; r.alu = 9; r.ca = 1; end
               6'h04: begin r.kind = K_ALU; r.alu = 7; r.ca = 0; end
               6'h06: begin r.kind = K_ALU; r.alu = 8; r.ca = 0; end
               6'h07: begin r.kind = K_ALU; r.alu = 9; r.ca = 0; end
               6'h08: begin r.kind = K_JR;  r.alu = (1 << AW) - 1; end
               default: r.kind = K_ILL;
            endcase
         end
      end else begin
         case (o)
            6'h08, 6'h09: begin r.kind = K_ALU; r.alu = 0;  r.se = 1; end
            6'h0c:        begin r.kind = K_ALU; r.alu = 2;  r.se = 0; end
            6'h0d:        begin r.kind = K_ALU; r.alu = 3;  r.se = 0; end
            6'h0e:        begin r.kind = K_ALU; r.alu = 4;  r.se = 0; end
            6'h0f:        begin r.kind = K_ALU; r.alu = 10; end
            6'h0a:        begin r.kind = K_ALU; r.alu = 6;  r.se = 1; end
            6'h0b:        begin r.kind = K_ALU; r.alu = 6;  r.se = 0; end
            6'h23:        begin r.kind = K_LW;  r.alu = 0;  r.cb = 1; r.se = 1; end
            6'h2b:        begin r.kind = K_SW;  r.alu = 0;  r.cb = 1; r.se = 1; end
            6'h04, 6'h05: begin r.kind = K_BR;  r.alu = 1; end
            6'h02:        r.kind = K_J;
            6'h03:        r.kind = K_JAL;
            default:      r.kind = K_ILL;
         endcase
         if (r.kind == K_ALU) begin
            r.cb = 1; r.dst = 0;
         end
      end
      return r;
   endfunction

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected outputs for one cycle in phase ph (0=F,1=D,2=E,3=M,4=W).
   task automatic checkOutput(input string tag, input int ph, input info_t inf,
                              input logic [5:0] o, input logic rdy, input logic e, input bit tmo);
      int eImem = 0, eDmem = 0, eMw = 0, eIrw = 0, ePcw = 0, eRegw = 0;
      int eIll = 0, eBerr = 0, eDone = 0, eNop = -1, eJal = -1, eM2r = -1;
      bit taken;
      case (ph)
         0: begin
            eImem = 1; eIrw = int'(rdy); eBerr = int'(!rdy && tmo);
         end
         1: if (inf.kind == K_ILL) begin
            eIll = 1; ePcw = 1; eNop = 0; eDone = 1;
         end
         2: begin
            eJal = (inf.kind == K_JAL) ? 1 : 0;
            case (inf.kind)
               K_BR: begin
                  taken = (o == 6'h05) ? !e : e;
                  ePcw = 1; eDone = 1; eNop = taken ? 1 : 0;
               end
               K_J:   begin ePcw = 1; eDone = 1; eNop = 2; end
               K_JR:  begin ePcw = 1; eDone = 1; eNop = 3; end
               K_JAL: begin ePcw = 1; eRegw = 1; eDone = 1; eNop = 2; end
               default: ;
            endcase
         end
         3: begin
            eDmem = 1;
            eBerr = int'(!rdy && tmo);
            eMw   = int'((inf.kind == K_SW) && !(!rdy && tmo));
            if (rdy && inf.kind == K_SW) begin
               ePcw = 1; eDone = 1; eNop = 0;
            end
         end
         default: begin
            eRegw = 1; ePcw = 1; eDone = 1; eNop = 0;
            eM2r = (inf.kind == K_LW) ? 1 : 0;
         end
      endcase
      compare({tag, "/state"},      32'(bus.state),      ph);
      compare({tag, "/imem_req"},   32'(bus.imem_req),   eImem);
      compare({tag, "/dmem_req"},   32'(bus.dmem_req),   eDmem);
      compare({tag, "/mem_write"},  32'(bus.mem_write),  eMw);
      compare({tag, "/ir_write"},   32'(bus.ir_write),   eIrw);
      compare({tag, "/pc_write"},   32'(bus.pc_write),   ePcw);
      compare({tag, "/reg_write"},  32'(bus.reg_write),  eRegw);
      compare({tag, "/illegal"},    32'(bus.illegal),    eIll);
      compare({tag, "/bus_err"},    32'(bus.bus_err),    eBerr);
      compare({tag, "/instr_done"}, 32'(bus.instr_done), eDone);
      if (eNop >= 0) compare({tag, "/next_op"},    32'(bus.next_op),    eNop);
      if (eJal >= 0) compare({tag, "/jal"},        32'(bus.jal),        eJal);
      if (eM2r >= 0) compare({tag, "/mem_to_reg"}, 32'(bus.mem_to_reg), eM2r);
      if (ph != 0 && inf.kind != K_ILL) begin
         if (inf.alu >= 0) compare({tag, "/alu_op"},    32'(bus.alu_op),    inf.alu);
         if (inf.ca >= 0)  compare({tag, "/control_a"}, 32'(bus.control_a), inf.ca);
         if (inf.cb >= 0)  compare({tag, "/control_b"}, 32'(bus.control_b), inf.cb);
         if (inf.se >= 0)  compare({tag, "/sign_ext"},  32'(bus.sign_ext),  inf.se);
         if (inf.dst >= 0) compare({tag, "/dest"},      32'(bus.dest),      inf.dst);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, then check.
   task automatic applyStimulus(input string tag, input int ph, input info_t inf,
                                input logic [5:0] o, input logic [5:0] f, input logic e,
                                input logic rdy, input bit tmo);
      @(negedge clk);
      bus.mem_ready = rdy;
      if (ph == 0) begin
         bus.op   = 6'($urandom);
         bus.func = 6'($urandom);
      end else begin
         bus.op   = o;
         bus.func = f;
      end
      bus.eq = (ph == 2) ? e : 1'($urandom);
      #1;
      cycleIdx++;
      if (bus.instr_done === 1'b1 && doneAt == 0) doneAt = cycleIdx;
      checkOutput(tag, ph, inf, o, rdy, e, tmo);
   endtask

   task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input logic e,
                           input int fw, input int mw, input bit fetchTmo, input bit memTmo);
      info_t inf;
      string tag;
      int    expDone;
      bit    isMem;
      inf   = classify(o, f);
      tag   = $sformatf("op%02h_f%02h", o, f);
      isMem = (inf.kind == K_LW) || (inf.kind == K_SW);
      cycleIdx = 0;
      doneAt   = 0;
      if (fetchTmo)
         for (int w = 0; w < TMO; w++) applyStimulus(tag, 0, inf, o, f, e, 1'b0, w == TMO - 1);
      for (int w = 0; w <= fw; w++) applyStimulus(tag, 0, inf, o, f, e, w == fw, 1'b0);
      applyStimulus(tag, 1, inf, o, f, e, 1'($urandom), 1'b0);
      if (inf.kind != K_ILL) begin
         applyStimulus(tag, 2, inf, o, f, e, 1'($urandom), 1'b0);
         if (isMem) begin
            if (memTmo)
               for (int w = 0; w < TMO; w++) applyStimulus(tag, 3, inf, o, f, e, 1'b0, w == TMO - 1);
            else
               for (int w = 0; w <= mw; w++) applyStimulus(tag, 3, inf, o, f, e, w == mw, 1'b0);
         end
         if (!memTmo && (inf.kind == K_ALU || inf.kind == K_LW))
            applyStimulus(tag, 4, inf, o, f, e, 1'($urandom), 1'b0);
      end
      case (inf.kind)
         K_ILL:      expDone = 2;
         K_ALU:      expDone = 4;
         K_LW:       expDone = 5;
         K_SW:       expDone = 4;
         default:    expDone = 3;
      endcase
      expDone += fw + (fetchTmo ? TMO : 0) + (isMem ? mw : 0);
      if (memTmo) expDone = 0;
      compare({tag, "/doneCycle"}, doneAt, expDone);
   endtask

   task automatic checkResetOutputs(input string tag);
      compare({tag, "/state"},      32'(bus.state),      0);
      compare({tag, "/imem_req"},   32'(bus.imem_req),   0);
      compare({tag, "/dmem_req"},   32'(bus.dmem_req),   0);
      compare({tag, "/mem_write"},  32'(bus.mem_write),  0);
      compare({tag, "/ir_write"},   32'(bus.ir_write),   0);
      compare({tag, "/pc_write"},   32'(bus.pc_write),   0);
      compare({tag, "/reg_write"},  32'(bus.reg_write),  0);
      compare({tag, "/illegal"},    32'(bus.illegal),    0);
      compare({tag, "/bus_err"},    32'(bus.bus_err),    0);
      compare({tag, "/instr_done"}, 32'(bus.instr_done), 0);
   endtask

   task automatic releaseReset(input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ready = 1'b0;
      #1;
      compare({tag, "/imem_req"}, 32'(bus.imem_req), 1);
      compare({tag, "/state"},    32'(bus.state),    0);
      compare({tag, "/ir_write"}, 32'(bus.ir_write), 0);
   endtask

   initial begin
      info_t      lwInf;
      logic [5:0] rOp, rFn;
      bus.op = 6'h00;
      bus.func = 6'h00;
      bus.eq = 1'b0;
      bus.mem_ready = 1'b1;
      rst_n = 1'b0;
      #2 checkResetOutputs("reset");
      releaseReset("release");

      runInstr(6'h00, 6'h21, 1'b0, 0, 0, 1'b0, 1'b0);
      runInstr(6'h23, 6'h00, 1'b0, 0, 2, 1'b0, 1'b0);
      runInstr(6'h04, 6'h11, 1'b1, 0, 0, 1'b0, 1'b0);
      runInstr(6'h05, 6'h11, 1'b1, 0, 0, 1'b0, 1'b0);
      runInstr(6'h03, 6'h3f, 1'b0, 1, 0, 1'b0, 1'b0);
      runInstr(6'h3f, 6'h20, 1'b0, 0, 0, 1'b0, 1'b0);
      runInstr(6'h00, 6'h01, 1'b0, 0, 0, 1'b0, 1'b0);
      runInstr(6'h2b, 6'h00, 1'b0, 0, 0, 1'b0, 1'b1);
      runInstr(6'h00, 6'h02, 1'b0, 2, 0, 1'b1, 1'b0);
      runInstr(6'h2b, 6'h05, 1'b0, 2, 2, 1'b0, 1'b0);

      // Reset dropped in the middle of a load's MEM wait.
      lwInf = classify(6'h23, 6'h00);
      applyStimulus("rstLw", 0, lwInf, 6'h23, 6'h00, 1'b0, 1'b1, 1'b0);
      applyStimulus("rstLw", 1, lwInf, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus("rstLw", 2, lwInf, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus("rstLw", 3, lwInf, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      #1 checkResetOutputs("rstMid");
      @(negedge clk);
      #1 checkResetOutputs("rstHeld");
      releaseReset("rstRelease");
      runInstr(6'h00, 6'h24, 1'b0, 0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         rOp = ($urandom_range(0, 4) == 0) ? 6'($urandom)
                                           : opList[$urandom_range(0, opList.size() - 1)];
         rFn = (rOp == 6'h00 && $urandom_range(0, 4) != 0)
               ? fnList[$urandom_range(0, fnList.size() - 1)] : 6'($urandom);
         runInstr(rOp, rFn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0);
      end

      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1 compare("final/state", 32'(bus.state), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle MIPS control unit: the sequential successor to the single-cycle decoder in the CPU datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB states and waits on a ready handshake for instruction and data memory. It strobes PC, IR, register-file and memory writes only in the proper state, so the datapath can share one ALU and one memory port. It adds illegal-instruction detection, a memory timeout, and a parametrised ALU-op width.

## Interface
- ALU_OP_W, 4, alu_op width (≥4); codes are zero-extended, "none" is all-ones.
- MEM_TIMEOUT, 0, maximum wait cycles for mem_ready; 0 disables the timeout.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op, func  in  6 each  opcode and funct; driven from the IR, so stable from DECODE to end of instruction.
- eq  in  1  rs==rt from ALU zero flag; valid in EXEC.
- mem_ready  in  1  memory access complete this cycle.
- imem_req, dmem_req, mem_write  out  1 each  memory request strobes.
- ir_write, pc_write, reg_write  out  1 each  write strobes.
- control_a  out  1  0 = rs, 1 = shamt.
- control_b  out  1  0 = rt, 1 = extended immediate.
- sign_ext  out  1  sign-extend the immediate.
- dest  out  1  1 = rd, 0 = rt.
- jal  out  1  write PC+4 to $31.
- mem_to_reg  out  1  writeback source is memory.
- alu_op  out  ALU_OP_W  ALU operation code.
- next_op  out  2  PC source: 00 = +4, 01 = branch, 10 = jump target, 11 = rs.
- illegal, bus_err, instr_done  out  1 each  single-cycle pulses.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

## Operation
- **Decode (combinational from op/func).**
  - ALU codes: add 0, sub 1, and 2, or 3, xor 4, nor 5, slt 6, sll 7, srl 8, sra 9, lui 10, none = all-ones.
  - R-type (op 000000), ALU funct:
    - add/addu (100000/100001) → 0; sub/subu (100010/100011) → 1.
    - and/or/xor/nor (100100–100111) → 2–5; slt/sltu (101010/101011) → 6.
    - All ALU funct: dest=1.
  - R-type shifts:
    - sll/srl/sra (000000/000010/000011) → 7/8/9 with control_a=1.
    - sllv/srlv/srav (000100/000110/000111) → same codes with control_a=0.
  - R-type jr (001000): next_op 11, alu_op none.
  - I-type, all control_b=1, dest=0:
    - addi/addiu (001000/001001) → 0, sext.
    - andi/ori/xori (001100/001101/001110) → 2/3/4, zext.
    - lui (001111) → 10; slti (001010) → 6, sext; sltiu (001011) → 6, zext.
  - lw (100011) and sw (101011): alu 0, control_b=1, sign_ext=1.
  - beq (000100) and bne (000101): alu 1.
  - j (000010) and jal (000011): next_op 10.
  - Every other op/func combination is illegal.
- **FETCH:** imem_req=1. On mem_ready: ir_write=1, go to DECODE.
- **DECODE:** control outputs valid. If illegal: illegal=1, pc_write=1, next_op=00, instr_done=1, go to FETCH. Otherwise go to EXEC.
- **EXEC, branch:** pc_write=1; next_op=01 if (beq & eq) | (bne & !eq), else 00.
- **EXEC, j/jr:** pc_write=1.
- **EXEC, jal:** pc_write=1 and reg_write=1, jal=1.
- **EXEC, exit:** all branch/jump cases above assert instr_done and go to FETCH. ALU ops go to WB; lw/sw go to MEM.
- **MEM:** dmem_req=1, mem_write=sw. On mem_ready: sw asserts pc_write and instr_done, goes to FETCH; lw goes to WB.
- **WB:** reg_write=1, mem_to_reg=lw, pc_write=1, next_op=00, instr_done=1, go to FETCH.
- **Strobe gating:** reg_write, mem_write and pc_write are never asserted outside the states listed above.
- **Timeout** (MEM_TIMEOUT>0):
  - A counter clears on entry to FETCH/MEM and increments each waiting cycle.
  - When it reaches MEM_TIMEOUT with no mem_ready: bus_err=1, no ir_write/pc_write/mem_write that cycle, go to FETCH.
  - A FETCH timeout re-fetches the same PC.
  - mem_ready on the limit cycle wins over the timeout.

## Timing
- Latency: ALU op 4 cycles, branch/jump 3, lw 5, sw 4, each with zero memory wait. Add one cycle per wait cycle.
- Strobes and next_op are Mealy outputs (state + mem_ready + decode), valid the same cycle. The datapath samples them on the next rising edge.
- Reset:
  - The state register goes to FETCH and the timeout counter to 0 asynchronously.
  - While rst_n=0, all strobes, pulses and the request outputs are 0; state output reads 0.
  - Fetch begins (imem_req=1) in the first cycle after release.
- Reset asserted mid-MEM aborts with no write. Writes are only committed on clock edges with rst_n=1.
- mem_ready outside FETCH/MEM is ignored.

## Test plan
- **addu:** addu (op 0, func 100001), mem_ready held 1 → states 0,1,2,4; in WB reg_write=1, dest=1, alu_op=0, pc_write=1; instr_done at cycle 4.
- **lw with wait:** lw with mem_ready low for 2 MEM cycles → dmem_req held 3 cycles, no mem_write, WB asserts mem_to_reg=1; 7 cycles total.
- **Branches:** beq with eq=1 → EXEC next_op=01, pc_write=1. bne with eq=1 → next_op=00.
- **jal:** jal → EXEC reg_write=1, jal=1, next_op=10; no WB state entered.
- **Illegal:** op 111111 → illegal pulse in DECODE, pc_write=1 with next_op=00; reg_write and mem_write never asserted.
- **Timeout and reset:** MEM_TIMEOUT=3, sw with mem_ready never asserted → bus_err on the 3rd MEM wait cycle, no mem_write, state back to 0. Separately, rst_n dropped mid-MEM → outputs 0 immediately, fetch resumes after release.
